gera_perf: RTL
==============

Name: gera_perf

Overview:
- Source side of the 3-bit profile-code interface (A,B,C) consumed by the profile validity checker.
- Lets the operator step through the four valid profiles with buttons, confirm one, and hold it as the active session profile.
- The session ends on logout or after a timeout.
- Output bits drive the checker's A,B,C inputs directly; every code emitted is always one of the four valid codes.

Parameters:
- SESSION_CYCLES, 50000000, active-session length in clk cycles (1 s at 50 MHz); must be >= 2
- CNT_W, 26, session counter width; must satisfy 2**CNT_W > SESSION_CYCLES

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- btn_next  input  1  level, already synchronised/debounced; rising edge = next profile
- btn_prev  input  1  level; rising edge = previous profile
- btn_confirm  input  1  level; rising edge = log in with current profile
- btn_logout  input  1  level; rising edge = end session
- A  output  1  profile code bit 2
- B  output  1  profile code bit 1
- C  output  1  profile code bit 0
- active  output  1  high while a session is running
- perf_valid  output  1  one-cycle pulse when a profile is confirmed
- expired  output  1  one-cycle pulse when a session ends by timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Profile codes {A,B,C}: ADM=101, TESTER=011, USER=001, GUEST=110.
  - Index order: 0=ADM, 1=TESTER, 2=USER, 3=GUEST.
  - A, B and C are registered, decoded from a 2-bit index register.
- Edge detection:
  - Each button has a registered previous-value flop.
  - An event is btn & ~btn_q, evaluated at each rising clk edge.
  - A button held high produces exactly one event.
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE, idx=0, so {A,B,C}=101.
  - active=0, perf_valid=0, expired=0, counter=0.
  - All btn_q flops = 0.
  - Applies from any state, including mid-session.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - next event: idx+1 mod 4 (GUEST wraps to ADM).
  - prev event: idx-1 mod 4 (ADM wraps to GUEST).
  - next and prev events in the same cycle: both ignored, idx unchanged.
  - confirm event (takes priority over next/prev in the same cycle; idx unchanged):
    - state goes to ACTIVE, active=1.
    - perf_valid=1 for exactly one cycle.
    - counter loaded with SESSION_CYCLES-1.
  - logout event: ignored.
- ACTIVE:
  - next, prev and confirm events are ignored; {A,B,C} is frozen.
  - counter decrements by 1 each cycle.
  - logout event: state goes to IDLE, active=0, no expired pulse.
  - Timeout: in the cycle where counter==0 with no logout event, state goes to IDLE, active=0, expired=1 for one cycle.
  - Logout event in the same cycle as counter==0: treated as logout, expired stays 0.
  - Session length: active stays high for exactly SESSION_CYCLES cycles when no logout occurs.
- Return to IDLE: idx is preserved, so the last profile is shown again.
- Latency: 1 cycle from the clk edge that samples a button rise to the updated A/B/C, active and pulse outputs.
- Output timing: perf_valid and expired are registered, never combinational.

Decomposition:
- Shared package/include perf_defs:
  - code constants PERF_ADM=3'b101, PERF_TESTER=3'b011, PERF_USER=3'b001, PERF_GUEST=3'b110
  - state encodings ST_IDLE, ST_ACTIVE
- The existing validity checker uses the same constants.
- Sub-module detecta_borda: one-bit rising-edge detector (clk, rst_n, in, pulse), instantiated four times.

Test Plan:
- Reset, then 5 next rises (each 2 cycles high) -> {A,B,C} sequence 011,001,110,101,011; active=0; checker out=1 throughout.
- From ADM, 1 prev rise -> {A,B,C}=110 (wrap to GUEST); btn_next and btn_prev rise same cycle -> code unchanged.
- SESSION_CYCLES=8, select USER, confirm -> perf_valid high exactly 1 cycle; active high 8 cycles; expired pulse 1 cycle; code stays 001; next presses during session ignored.
- Confirm, logout 3 cycles later -> active drops 1 cycle after the logout rise; expired stays 0; next rise afterwards moves 001 to 110.
- Logout rise aligned with counter==0 -> active drops, expired=0. Hold btn_confirm high for 20 cycles -> only one perf_valid pulse.
- Confirm TESTER, assert rst_n=0 for 1 cycle mid-session -> next cycle active=0, {A,B,C}=101, no pulses.

Source files
------------

// File: rtl/perf_defs.sv
// Shared profile-code definitions for the gera_perf source and the profile
// validity checker: the four legal {A,B,C} codes and the session FSM states.
package perf_defs;

    localparam logic [2:0] PERF_ADM    = 3'b101;
    localparam logic [2:0] PERF_TESTER = 3'b011;
    localparam logic [2:0] PERF_USER   = 3'b001;
    localparam logic [2:0] PERF_GUEST  = 3'b110;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } perf_state_t;

    // Map the 2-bit profile index (0=ADM, 1=TESTER, 2=USER, 3=GUEST) to its code.
    // Every index maps to a legal code, so the outputs can never show an
    // invalid profile.
    function automatic logic [2:0] perf_code(input logic [1:0] idx);
        logic [2:0] code;
        code = PERF_ADM;
        case (idx)
            2'd0: code = PERF_ADM;
            2'd1: code = PERF_TESTER;
            2'd2: code = PERF_USER;
            2'd3: code = PERF_GUEST;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/detecta_borda.sv
// One-bit rising-edge detector. The input is already synchronised, so a single
// registered copy of the previous value is enough. A level held high yields
// exactly one pulse, in the cycle its rise is first sampled.
module detecta_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Remember the previous sampled level of the input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/gera_perf.sv
// Profile-code source for the validity checker. Buttons step through the four
// legal profiles while idle; confirm starts a timed session that freezes the
// code until logout or timeout. All outputs are registered.
module gera_perf
    import perf_defs::*;
#(
    parameter int SESSION_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_next,
    input  logic btn_prev,
    input  logic btn_confirm,
    input  logic btn_logout,
    output logic A,
    output logic B,
    output logic C,
    output logic active,
    output logic perf_valid,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SESSION_CYCLES - 1);

    logic             ev_next;
    logic             ev_prev;
    logic             ev_confirm;
    logic             ev_logout;

    perf_state_t      state;
    logic [1:0]       idx;
    logic [2:0]       code;
    logic [CNT_W-1:0] counter;

    detecta_borda u_edge_next (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_next),
        .pulse (ev_next)
    );

    detecta_borda u_edge_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_prev),
        .pulse (ev_prev)
    );

    detecta_borda u_edge_confirm (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_confirm),
        .pulse (ev_confirm)
    );

    detecta_borda u_edge_logout (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_logout),
        .pulse (ev_logout)
    );

    // Session FSM: profile selection in IDLE, countdown and frozen code in ACTIVE.
    // The code register is loaded together with idx so it always matches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            code       <= PERF_ADM;
            active     <= 1'b0;
            perf_valid <= 1'b0;
            expired    <= 1'b0;
            counter    <= '0;
        end else begin
            perf_valid <= 1'b0;
            expired    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_confirm) begin
                        state      <= ST_ACTIVE;
                        active     <= 1'b1;
                        perf_valid <= 1'b1;
                        counter    <= CNT_LOAD;
                    end else if (ev_next && !ev_prev) begin
                        idx  <= idx + 2'd1;
                        code <= perf_code(idx + 2'd1);
                    end else if (ev_prev && !ev_next) begin
                        idx  <= idx - 2'd1;
                        code <= perf_code(idx - 2'd1);
                    end
                end
                ST_ACTIVE: begin
                    if (ev_logout) begin
                        // Logout wins over a coincident timeout: no expired pulse.
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end else if (counter == '0) begin
                        state   <= ST_IDLE;
                        active  <= 1'b0;
                        expired <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign A = code[2];
    assign B = code[1];
    assign C = code[0];

endmodule
